// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory arbiter of the MIPS core.
// State encoding, default widths and the starvation limit.
package mips_mem_pkg;

    localparam int AW_DEF         = 32;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        S_ARB_IDLE    = 2'b00,
        S_ARB_BUSY_IF = 2'b01,
        S_ARB_BUSY_DM = 2'b10
    } arbState_t;

    function automatic logic [CNT_W-1:0] satInc(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] lim
    );
        return (val < lim) ? val + 1'b1 : val;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority DM-over-IF arbiter for the single-port unified memory,
// with a starvation guard that forces an IF grant after STARVE_MAX DM wins.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          iIfReq,
    input  logic [AW-1:0] iIfAddr,
    output logic          oIfGnt,
    output logic          oIfValid,
    output logic [DW-1:0] oIfRdata,
    input  logic          iDmReq,
    input  logic          iDmWe,
    input  logic [AW-1:0] iDmAddr,
    input  logic [DW-1:0] iDmWdata,
    output logic          oDmGnt,
    output logic          oDmValid,
    output logic [DW-1:0] oDmRdata,
    output logic          oMemCs,
    output logic          oMemWe,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemWdata,
    input  logic          iMemAck,
    input  logic [DW-1:0] iMemRdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arbState_t        state;
    arbState_t        stateNext;
    logic [CNT_W-1:0] starveCnt;
    logic             ifWin;
    logic             dmWin;
    logic             ifDone;
    logic             dmDone;
    logic             ifForced;

    assign ifForced = iIfReq && (starveCnt == CNT_MAX);
    assign ifDone   = (state == S_ARB_BUSY_IF) && iMemAck;
    assign dmDone   = (state == S_ARB_BUSY_DM) && iMemAck;

    always_comb begin
        stateNext = state;
        ifWin     = 1'b0;
        dmWin     = 1'b0;
        unique case (state)
            S_ARB_IDLE: begin
                if (iDmReq && !ifForced) begin
                    dmWin     = 1'b1;
                    stateNext = S_ARB_BUSY_DM;
                end else if (iIfReq) begin
                    ifWin     = 1'b1;
                    stateNext = S_ARB_BUSY_IF;
                end
            end
            S_ARB_BUSY_IF,
            S_ARB_BUSY_DM: begin
                if (iMemAck) begin
                    stateNext = S_ARB_IDLE;
                end
            end
            default: stateNext = S_ARB_IDLE;
        endcase
    end

    assign oIfGnt = ifWin;
    assign oDmGnt = dmWin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Only DM wins taken while IF is actually waiting count toward starvation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starveCnt <= '0;
        end else if (ifWin) begin
            starveCnt <= '0;
        end else if (dmWin && iIfReq) begin
            starveCnt <= satInc(starveCnt, CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oMemCs    <= 1'b0;
            oMemWe    <= 1'b0;
            oMemAddr  <= '0;
            oMemWdata <= '0;
        end else if (ifWin) begin
            oMemCs    <= 1'b1;
            oMemWe    <= 1'b0;
            oMemAddr  <= iIfAddr;
            oMemWdata <= '0;
        end else if (dmWin) begin
            oMemCs    <= 1'b1;
            oMemWe    <= iDmWe;
            oMemAddr  <= iDmAddr;
            oMemWdata <= iDmWe ? iDmWdata : '0;
        end else if (ifDone || dmDone) begin
            oMemCs    <= 1'b0;
            oMemWe    <= 1'b0;
            oMemAddr  <= '0;
            oMemWdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oIfValid <= 1'b0;
            oDmValid <= 1'b0;
            oIfRdata <= '0;
            oDmRdata <= '0;
        end else begin
            oIfValid <= ifDone;
            oDmValid <= dmDone;
            if (ifDone) begin
                oIfRdata <= iMemRdata;
            end
            // A store completion pulses valid but keeps the last load data.
            if (dmDone && !oMemWe) begin
                oDmRdata <= iMemRdata;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory between instruction fetch (IF) and data load/store (DM) in the MIPS core.
- Requesters use a req/gnt handshake; the memory side uses a cs/ack handshake.
- Arbitration is fixed-priority DM over IF, with a starvation guard that forces an IF grant after STARVE_MAX consecutive DM grants.
- Sits between the PC/fetch logic, the load/store unit (driven by control's oMemRd/oMemWr) and the memory model.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive DM grants while IF waits before IF is forced; range 1..15

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- iIfReq  in  1  fetch request; held until oIfGnt
- iIfAddr  in  AW  fetch address
- oIfGnt  out  1  fetch grant, one-cycle pulse
- oIfValid  out  1  fetch data valid, one-cycle pulse
- oIfRdata  out  DW  fetched instruction
- iDmReq  in  1  data request; held until oDmGnt
- iDmWe  in  1  1 = store, 0 = load
- iDmAddr  in  AW  data address
- iDmWdata  in  DW  store data
- oDmGnt  out  1  data grant, one-cycle pulse
- oDmValid  out  1  load data returned / store done, one-cycle pulse
- oDmRdata  out  DW  load data
- oMemCs  out  1  memory select; held until iMemAck
- oMemWe  out  1  memory write enable
- oMemAddr  out  AW  memory address
- oMemWdata  out  DW  memory write data
- iMemAck  in  1  memory done; iMemRdata valid in the same cycle
- iMemRdata  in  DW  memory read data

Behaviour:
- Reset is asynchronous via resetn, active-low; clock is clk.
- Reset state is IDLE. All outputs are 0 and the starvation counter is 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, no request: stay in IDLE.
- IDLE, only iDmReq: go to BUSY_DM.
- IDLE, only iIfReq: go to BUSY_IF.
- IDLE, both requesting: go to BUSY_IF if starve_cnt == STARVE_MAX, else BUSY_DM.
- Grants are combinational (Mealy). oIfGnt/oDmGnt is asserted only in the IDLE cycle where that requester wins. Address, write-enable and write data are captured at that clock edge.
- A requester may present a new request on the cycle after its grant.
- oMemCs, oMemWe, oMemAddr and oMemWdata are registered. They are driven from the cycle after the grant and held stable until and including the iMemAck cycle.
- oMemWe = 0 in BUSY_IF. oMemWdata = 0 when oMemWe = 0.
- BUSY_x with iMemAck: next state IDLE. The next cycle has oMemCs = 0 and oxValid = 1 for exactly one cycle.
- On a read, oxRdata is registered from iMemRdata at the ack edge. oxRdata holds its value until the next read completion for that port.
- Store completion pulses oDmValid and leaves oDmRdata unchanged.
- BUSY_x without iMemAck: wait indefinitely. There is no timeout.
- Minimum access: grant cycle, then one cycle with ack (next state IDLE), then the valid cycle, which is also the next arbitration cycle. Peak throughput is one access per 2 cycles.
- The IDLE cycle that follows an ack may arbitrate and grant in the same cycle that oxValid is high.
- Starvation counter (4 bits):
  - Increments on each DM grant made while iIfReq = 1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Unchanged otherwise.
- iMemAck seen in IDLE is ignored.
- Request inputs are ignored while BUSY.
- Reset mid-transaction:
  - Drops the transaction immediately: oMemCs = 0, no valid pulse, state IDLE, counter 0.
  - An ack arriving after reset release is ignored.

Decomposition:
- Shared package mips_mem_pkg:
  - State encoding constants S_ARB_IDLE = 2'b00, S_ARB_BUSY_IF = 2'b01, S_ARB_BUSY_DM = 2'b10.
  - Default AW/DW and STARVE_MAX.
- No sub-module. The FSM, counter and output registers are a single module.

Test Plan:
- Reset, then IF-only request to 0x100 with ack 2 cycles after cs, iMemRdata = 0x8C110064
  -> oIfGnt 1 cycle; oMemCs high 2 cycles with oMemAddr = 0x100 and oMemWe = 0; oIfValid pulse with oIfRdata = 0x8C110064.
- IF and DM request in the same cycle, DM store to 0x200 of 0xDEADBEEF, ack immediate
  -> DM granted first with oMemWe = 1 and oMemWdata = 0xDEADBEEF; oDmValid pulses; IF granted in the next IDLE cycle.
- IF held high while DM issues 6 back-to-back loads, STARVE_MAX = 4
  -> grant order DM,DM,DM,DM,IF,DM,DM; counter returns to 0 after the IF grant.
- DM load to 0x300, memory stalls 10 cycles before ack with 0x12345678
  -> oMemCs and oMemAddr stable for all 10 cycles, no grants during the stall, oDmRdata = 0x12345678.
- resetn pulsed low while in BUSY_DM, then ack asserted 2 cycles after release
  -> oMemCs = 0 immediately; no oDmValid; state IDLE; the late ack is ignored.
- Back-to-back IF fetches to 0x0, 0x4, 0x8 with ack immediate
  -> a grant every 2 cycles; oIfValid of fetch k coincides with oIfGnt of fetch k+1.
